// File: rtl/bus_cycle_gen_8088.sv
// 8088-style bus cycle initiator: turns one host request into T1-T2-T3-[Tw]-T4 with status for an 8288.
// Define INTA_DOUBLE_EN to run INTA as two back-to-back bus cycles separated by one Ti.
module bus_cycle_gen_8088 #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  req_type,
  input  logic [19:0] addr,
  input  logic [7:0]  wdata,
  input  logic        ready,
  input  logic [7:0]  ad_in,
  output logic [2:0]  s_n,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [11:0] a_hi,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_TI} state_t;

  localparam logic [2:0] ST_INTA  = 3'b000;
  localparam logic [2:0] ST_IOR   = 3'b001;
  localparam logic [2:0] ST_IOW   = 3'b010;
  localparam logic [2:0] ST_HALT  = 3'b011;
  localparam logic [2:0] ST_FETCH = 3'b100;
  localparam logic [2:0] ST_MEMR  = 3'b101;
  localparam logic [2:0] ST_MEMW  = 3'b110;
  localparam logic [2:0] ST_NONE  = 3'b111;
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [2:0]        type_q;
  logic [19:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              abort_q;
  logic              accept, capture, wait_inc, timeout, first_pass;
  logic              is_read, is_write;

  assign is_read  = (type_q == ST_INTA) || (type_q == ST_IOR) ||
                    (type_q == ST_FETCH) || (type_q == ST_MEMR);
  assign is_write = (type_q == ST_IOW) || (type_q == ST_MEMW);
  assign a_hi     = addr_q[19:8];
  assign rdata    = rdata_q;
  assign busy     = (state_q != S_IDLE);

`ifdef INTA_DOUBLE_EN
  // Set once the first INTA pulse has finished; selects capture/done for the second.
  logic second_q;
  assign first_pass = (type_q == ST_INTA) && !second_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      second_q <= 1'b0;
    end else if (accept) begin
      second_q <= 1'b0;
    end else if (state_q == S_T4 && first_pass && !abort_q) begin
      second_q <= 1'b1;
    end
  end
`else
  assign first_pass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    wait_inc = 1'b0;
    timeout  = 1'b0;
    s_n      = ST_NONE;
    ad_out   = 8'h00;
    ad_oe    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && req_type != ST_NONE) begin
          accept  = 1'b1;
          state_d = S_T1;
        end
      end
      S_T1: begin
        s_n     = type_q;
        ad_out  = addr_q[7:0];
        ad_oe   = 1'b1;
        state_d = (type_q == ST_HALT) ? S_T4 : S_T2;
      end
      S_T2: begin
        s_n     = type_q;
        ad_out  = is_write ? wdata_q : 8'h00;
        ad_oe   = is_write;
        state_d = S_T3;
      end
      S_T3, S_TW: begin
        s_n    = type_q;
        ad_out = is_write ? wdata_q : 8'h00;
        ad_oe  = is_write;
        if (ready) begin
          capture = is_read && !first_pass;
          state_d = S_T4;
        end else if (MAX_WAIT != 0 && cnt_q == MAX_CNT) begin
          timeout = 1'b1;
          state_d = S_T4;
        end else begin
          wait_inc = 1'b1;
          state_d  = S_TW;
        end
      end
      S_T4: begin
        if (first_pass && !abort_q) begin
          state_d = S_TI;
        end else begin
          done    = 1'b1;
          err     = abort_q;
          state_d = S_IDLE;
        end
      end
      S_TI:    state_d = S_T1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      type_q  <= ST_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      if (accept) begin
        type_q  <= req_type;
        addr_q  <= addr;
        wdata_q <= wdata;
        abort_q <= 1'b0;
      end
      if (capture) begin
        rdata_q <= ad_in;
      end
      if (timeout) begin
        abort_q <= 1'b1;
      end
      if (state_q == S_T4) begin
        cnt_q <= '0;
      end else if (wait_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_gen_8088.sv
// Randomized scoreboard bench for bus_cycle_gen_8088: expected per-clock bus activity and read results
// are derived from bus-cycle rules and queued at issue; independent monitors compare as the DUT responds.
module tb_bus_cycle_gen_8088;

  localparam int MAX_WAIT = 15;
  localparam logic [2:0] INTA = 3'b000, IOR = 3'b001, IOW = 3'b010, HALT = 3'b011;
  localparam logic [2:0] FETCH = 3'b100, MEMR = 3'b101, MEMW = 3'b110, NONE = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  req_type = NONE;
  logic [19:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        ready = 1'b0;
  logic [7:0]  ad_in = '0;
  logic [2:0]  s_n;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [11:0] a_hi;
  logic [7:0]  rdata;
  logic        busy, done, err;

  bus_cycle_gen_8088 #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_type(req_type), .addr(addr),
    .wdata(wdata), .ready(ready), .ad_in(ad_in), .s_n(s_n), .ad_out(ad_out),
    .ad_oe(ad_oe), .a_hi(a_hi), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  s;
    logic        oe;
    logic [7:0]  out;
    logic [11:0] ahi;
    logic        dn;
    logic        er;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] txn_q[$];
  logic [7:0] rd_model = 8'h00;
  logic [11:0] last_ahi = 12'h000;
  logic       rst_seen = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always @(posedge clk) rst_seen <= reset;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle as the sequence of clocks it should occupy.
  task automatic push_cycle(input logic [2:0] t, input logic [19:0] a, input logic [7:0] wd,
                            input int waits, input bit abort, input bit last);
    bus_t e;
    bit   wr;
    wr    = (t == IOW) || (t == MEMW);
    e.s   = t;
    e.oe  = 1'b1;
    e.out = a[7:0];
    e.ahi = a[19:8];
    e.dn  = 1'b0;
    e.er  = 1'b0;
    bus_q.push_back(e);
    if (t != HALT) begin
      e.oe  = wr;
      e.out = wr ? wd : 8'h00;
      repeat (2 + waits) bus_q.push_back(e);
    end
    e.s   = NONE;
    e.oe  = 1'b0;
    e.out = 8'h00;
    e.dn  = last;
    e.er  = abort && last;
    bus_q.push_back(e);
  endtask

  task automatic model_txn(input logic [2:0] t, input logic [19:0] a, input logic [7:0] wd,
                           input logic [7:0] d, input int nwait);
    bit   abort;
    int   waits;
    bus_t ti;
    abort = (t != HALT) && (nwait > MAX_WAIT);
    waits = (t == HALT) ? 0 : (abort ? MAX_WAIT : nwait);
`ifdef INTA_DOUBLE_EN
    if (t == INTA && !abort) begin
      push_cycle(t, a, wd, waits, 1'b0, 1'b0);
      ti.s = NONE; ti.oe = 1'b0; ti.out = 8'h00; ti.ahi = a[19:8]; ti.dn = 1'b0; ti.er = 1'b0;
      bus_q.push_back(ti);
      push_cycle(t, a, wd, 0, 1'b0, 1'b1);
    end else
`endif
    push_cycle(t, a, wd, waits, abort, 1'b1);
    if ((t == INTA || t == IOR || t == FETCH || t == MEMR) && !abort) rd_model = d;
    txn_q.push_back(rd_model);
  endtask

  // Called at posedge+1 of an idle clock. READY is held low for nwait clocks from T3 on;
  // AD carries junk except when READY is high. rst_at>0 asserts reset in that clock.
  task automatic issue(input logic [2:0] t, input logic [19:0] a, input logic [7:0] wd,
                       input logic [7:0] d, input int nwait, input bit junk, input int rst_at);
    int c;
    req = 1'b1; req_type = t; addr = a; wdata = wd;
    model_txn(t, a, wd, d, nwait);
    @(posedge clk); #1;
    req = 1'b0;
    c = 1;
    while (busy && c < 200) begin
      ready = (c >= 3 + nwait);
      ad_in = ready ? d : 8'($urandom);
      if (junk && $urandom_range(0, 1) == 1) begin
        req = 1'b1; req_type = 3'($urandom_range(0, 7));
        addr = 20'($urandom); wdata = 8'($urandom);
      end else begin
        req = 1'b0;
      end
      if (c == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        bus_q.delete();
        txn_q.delete();
        rd_model = 8'h00;
        reset = 1'b0;
        req = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      c++;
    end
    req = 1'b0;
    ready = 1'b0;
    if (busy) chk("cycle_budget", busy, 0);
  endtask

  // Bus / result monitor.
  initial begin
    bus_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_s_n", s_n, NONE);
        chk("rst_ad_oe", ad_oe, 0);
        chk("rst_ad_out", ad_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_a_hi", a_hi, 0);
        chk("rst_rdata", rdata, 0);
        last_ahi = 12'h000;
      end else if (busy) begin
        if (bus_q.size() == 0) begin
          chk("busy_unexpected", busy, 0);
        end else begin
          e = bus_q.pop_front();
          chk("s_n", s_n, e.s);
          chk("ad_oe", ad_oe, e.oe);
          if (e.oe) chk("ad_out", ad_out, e.out);
          chk("a_hi", a_hi, e.ahi);
          chk("done", done, e.dn);
          chk("err", err, e.er);
          last_ahi = e.ahi;
        end
      end else begin
        chk("idle_s_n", s_n, NONE);
        chk("idle_ad_oe", ad_oe, 0);
        chk("idle_done", done, 0);
        chk("idle_a_hi_hold", a_hi, last_ahi);
      end
      if (done) begin
        if (txn_q.size() == 0) chk("done_unexpected", done, 0);
        else chk("rdata", rdata, txn_q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0] t;
    int         nw;
    req = 1'b1; req_type = MEMR; addr = 20'hF1234;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    issue(MEMR, 20'hF1234, 8'h00, 8'h5A, 0, 1'b0, 0);
    issue(IOW, 20'h00061, 8'hC3, 8'h00, 3, 1'b1, 0);
    issue(MEMR, 20'h12345, 8'h00, 8'hEE, 20, 1'b0, 0);
    issue(INTA, 20'h00000, 8'h00, 8'h08, 0, 1'b0, 0);
    issue(HALT, 20'hABCDE, 8'h11, 8'h00, 0, 1'b1, 0);
    issue(IOR, 20'h003F8, 8'h00, 8'h77, 15, 1'b0, 0);
    issue(INTA, 20'h00000, 8'h00, 8'h99, 16, 1'b0, 0);
    issue(IOR, 20'h00123, 8'h00, 8'h44, 10, 1'b0, 5);
    req = 1'b1; req_type = NONE; addr = 20'hFFFFF;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      t = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 7))
        0: nw = 0;
        1: nw = 1;
        2: nw = 2;
        3: nw = 3;
        4: nw = 15;
        5: nw = 16;
        default: nw = $urandom_range(0, 5);
      endcase
      issue(t, 20'($urandom), 8'($urandom), 8'($urandom), nw, 1'b1, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_drained", bus_q.size(), 0);
    chk("txn_q_drained", txn_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
